muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit - iterative RV64M multiply/divide execute unit.
//
// Radix-2 datapath that retires one bit per cycle. Multiply is a shift-add on
// operand magnitudes. Divide is a restoring shift-subtract on magnitudes. The
// sign is fixed up in a single correction cycle afterwards. Divide-by-zero and
// signed overflow are resolved at acceptance and skip the iteration phase.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request, sampled only while accepting (IDLE or DONE)
//   md_op   funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   a, b    rs1 / rs2 operands
//   busy    operation in flight; starts are ignored
//   done    one-cycle pulse, result valid
//   result  held from done until the next operation's done

module muldiv_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int            CW   = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Latched request: everything the later phases need from acceptance.
   typedef struct packed {
      logic [2:0] op;
      logic       neg;    // negate the final product / quotient / remainder
      logic       fast;   // acc[XLEN-1:0] already holds the final answer
   } req_t;

   state_t          state;
   req_t            req;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] opd;      // multiplicand for MUL*, divisor for DIV*
   logic [2*XLEN-1:0] acc;    // MUL*: {partial hi, multiplier/lo}; DIV*: {rem, quo}

   // ---------------- acceptance decode ----------------
   logic            is_div, is_rem, sgn_a, sgn_b, a_neg, b_neg;
   logic            div_zero, div_ovf, fast;
   logic [XLEN-1:0] a_mag, b_mag, fast_val;

   assign is_div = md_op[2];
   assign is_rem = md_op[2] & md_op[1];
   // MUL/MULH/MULHSU treat a as signed; MUL/MULH treat b as signed;
   // DIV/REM treat both as signed.
   assign sgn_a  = md_op[2] ? ~md_op[0] : (md_op[1:0] != 2'b11);
   assign sgn_b  = md_op[2] ? ~md_op[0] : ~md_op[1];
   assign a_neg  = sgn_a & a[XLEN-1];
   assign b_neg  = sgn_b & b[XLEN-1];
   assign a_mag  = a_neg ? ({XLEN{1'b0}} - a) : a;
   assign b_mag  = b_neg ? ({XLEN{1'b0}} - b) : b;

   assign div_zero = is_div & (b == {XLEN{1'b0}});
   assign div_ovf  = is_div & sgn_a & (a == {1'b1, {(XLEN-1){1'b0}}})
                     & (b == {XLEN{1'b1}});
   assign fast     = div_zero | div_ovf;

   always_comb begin
      fast_val = {XLEN{1'b0}};
      if (div_zero)
         fast_val = is_rem ? a : {XLEN{1'b1}};
      else if (div_ovf)
         fast_val = is_rem ? {XLEN{1'b0}} : a;
   end

   // ---------------- iteration step ----------------
   logic [XLEN:0]     msum;
   logic [2*XLEN-1:0] mul_nxt;
   logic [XLEN:0]     trial;
   logic              ge;
   logic [XLEN-1:0]   rsub;
   logic [2*XLEN-1:0] div_nxt;

   assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : {(XLEN+1){1'b0}});
   assign mul_nxt = {msum, acc[XLEN-1:1]};

   // Shift the next dividend bit into the partial remainder and try the subtract.
   // When it fits, the difference is below the divisor so XLEN bits suffice.
   assign trial   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign ge      = trial >= {1'b0, opd};
   assign rsub    = trial[XLEN-1:0] - opd;
   assign div_nxt = ge ? {rsub, acc[XLEN-2:0], 1'b1}
                       : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};

   // ---------------- sign correction / output select ----------------
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   fix_val;

   assign prod_s = req.neg ? ({(2*XLEN){1'b0}} - acc) : acc;

   always_comb begin
      fix_val = {XLEN{1'b0}};
      if (req.fast)
         fix_val = acc[XLEN-1:0];
      else if (!req.op[2])
         fix_val = (req.op[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      else if (req.op[1])
         fix_val = req.neg ? ({XLEN{1'b0}} - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
      else
         fix_val = req.neg ? ({XLEN{1'b0}} - acc[XLEN-1:0]) : acc[XLEN-1:0];
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         req    <= '0;
         cnt    <= '0;
         opd    <= '0;
         acc    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  req.op   <= md_op;
                  // remainder follows the dividend; product/quotient the sign xor
                  req.neg  <= is_rem ? a_neg : (a_neg ^ b_neg);
                  req.fast <= fast;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  if (fast) begin
                     acc   <= {{XLEN{1'b0}}, fast_val};
                     opd   <= '0;
                     state <= S_FIX;
                  end else begin
                     acc   <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                     opd   <= is_div ? b_mag : a_mag;
                     state <= S_CALC;
                  end
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_CALC: begin
               acc <= req.op[2] ? div_nxt : mul_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == LAST)
                  state <= S_FIX;
            end
            S_FIX: begin
               result <= fix_val;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [2:0]  md_op;
   logic [63:0] a, b;
   logic        busy, done;
   logic [63:0] result;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q[$];
   string       name_q[$];
   logic [63:0] sb_e;
   string       sb_n;

   muldiv_unit #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .start(start), .md_op(md_op),
      .a(a), .b(b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // Scoreboard: every done pops the oldest expected result.
   always @(negedge clk) begin
      if (!rst && done) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done result=%h", result);
         end else begin
            sb_e = exp_q.pop_front();
            sb_n = name_q.pop_front();
            if (result !== sb_e) begin
               failures++;
               $display("FAIL %s result: got %h expected %h", sb_n, result, sb_e);
            end
         end
      end
   end

   // Reference model built on the simulator's own * / % operators.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y);
      logic [127:0] xe, ye, p;
      logic         sx, sy;
      if (!op[2]) begin
         sx = (op != 3'd3);
         sy = (op == 3'd0) || (op == 3'd1);
         xe = sx ? {{64{x[63]}}, x} : {64'd0, x};
         ye = sy ? {{64{y[63]}}, y} : {64'd0, y};
         p  = xe * ye;
         return (op == 3'd0) ? p[63:0] : p[127:64];
      end
      if (y == 64'd0) return op[1] ? x : 64'hFFFF_FFFF_FFFF_FFFF;
      if (!op[0]) begin
         if (x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF)
            return op[1] ? 64'd0 : x;
         return op[1] ? 64'($signed(x) % $signed(y)) : 64'($signed(x) / $signed(y));
      end
      return op[1] ? (x % y) : (x / y);
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y);
      if (op[2] && (y == 64'd0)) return 2;
      if (op[2] && !op[0] && x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF) return 2;
      return 66;
   endfunction

   // Drive a request for the next edge and record its expected result.
   task automatic launch(input string n, input logic [2:0] op, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] e);
      md_op = op; a = x; b = y; start = 1'b1;
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   // Step until done (bounded). Operands are scrambled right after acceptance,
   // and at cycle disturb_at a fresh start with different operands is pulsed.
   task automatic wait_done(input int disturb_at, output int lat, output int busy_cycles,
                            output logic busy_at_done, output logic [63:0] mid_res);
      lat = -1; busy_cycles = 0; busy_at_done = 1'bx; mid_res = 'x;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (c == disturb_at) begin
            start = 1'b1; md_op = 3'd5; a = 64'd9; b = 64'd0;
         end else begin
            start = 1'b0;
         end
         if (c == 1) begin
            a = ~a; b = {$urandom, $urandom}; md_op = ~md_op;
         end
         if (c == 33) mid_res = result;
         if (done) begin
            lat = c; busy_at_done = busy;
            break;
         end
         if (busy) busy_cycles++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; md_op = 3'd0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b expected 0", done); end
      checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got %h expected 0", result); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_normal_ops();
      logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
      logic [63:0] xs  [8] = '{64'd7, '1, '1, '1, -64'sd7, -64'sd7, 64'd100, 64'd100};
      logic [63:0] ys  [8] = '{-64'sd3, '1, '1, 64'd2, 64'd2, 64'd2, 64'd7, 64'd7};
      logic [63:0] es  [8] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'd14, 64'd2};
      int lat, bc; logic bd; logic [63:0] mr;
      for (int i = 0; i < 8; i++) begin
         launch($sformatf("normal_op%0d_%0d", i, ops[i]), ops[i], xs[i], ys[i], es[i]);
         wait_done(0, lat, bc, bd, mr);
         checks++; if (lat !== 66) begin failures++; $display("FAIL normal%0d_latency got %0d expected 66", i, lat); end
         checks++; if (bc !== 65) begin failures++; $display("FAIL normal%0d_busy_cycles got %0d expected 65", i, bc); end
         checks++; if (bd !== 1'b0) begin failures++; $display("FAIL normal%0d_busy_at_done got %b expected 0", i, bd); end
         @(posedge clk); #1;
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL normal%0d_done_width got %b expected 0", i, done); end
      end
   endtask

   task automatic test_fast_path();
      logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
      logic [63:0] xs  [4] = '{64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
      logic [63:0] ys  [4] = '{64'd0, 64'd0, '1, '1};
      logic [63:0] es  [4] = '{'1, 64'd5, 64'h8000_0000_0000_0000, 64'd0};
      int lat, bc; logic bd; logic [63:0] mr;
      for (int i = 0; i < 4; i++) begin
         launch($sformatf("fast%0d", i), ops[i], xs[i], ys[i], es[i]);
         wait_done(0, lat, bc, bd, mr);
         checks++; if (lat !== 2) begin failures++; $display("FAIL fast%0d_latency got %0d expected 2", i, lat); end
         checks++; if (bc !== 1) begin failures++; $display("FAIL fast%0d_busy_cycles got %0d expected 1", i, bc); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc; logic bd; logic [63:0] mr;
      // start pulsed at cycle 10 with other operands must be ignored
      launch("ignore_mul", 3'd0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB);
      wait_done(10, lat, bc, bd, mr);
      checks++; if (lat !== 66) begin failures++; $display("FAIL ignore_latency got %0d expected 66", lat); end
      // new start in the DONE cycle
      launch("b2b_mulhu", 3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
      wait_done(0, lat, bc, bd, mr);
      checks++; if (lat !== 66) begin failures++; $display("FAIL b2b_latency got %0d expected 66", lat); end
      checks++; if (mr !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL b2b_result_held got %h expected %h", mr, 64'hFFFF_FFFF_FFFF_FFEB); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int lat, bc; logic bd; logic [63:0] mr;
      launch("aborted_div", 3'd4, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      // reset wins over a simultaneous start
      rst = 1'b1; start = 1'b1; md_op = 3'd5; a = 64'd1; b = 64'd0;
      @(posedge clk); #1;
      start = 1'b0; rst = 1'b0;
      exp_q.delete(); name_q.delete();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got %b expected 0", done); end
      checks++; if (result !== 64'd0) begin failures++; $display("FAIL midrst_result got %h expected 0", result); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got busy=%b expected 0", busy); end
      launch("post_rst_divu", 3'd5, 64'd100, 64'd7, 64'd14);
      wait_done(0, lat, bc, bd, mr);
      checks++; if (lat !== 66) begin failures++; $display("FAIL post_rst_latency got %0d expected 66", lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat, bc; logic bd; logic [63:0] mr;
      logic [2:0] op; logic [63:0] x, y;
      for (int i = 0; i < 10; i++) begin
         op = 3'($urandom_range(0, 7));
         x  = {$urandom, $urandom};
         y  = (i % 4 == 3) ? 64'd0 : {$urandom, $urandom};
         if (i % 3 == 1) y = y >> 40;
         launch($sformatf("rand%0d_op%0d", i, op), op, x, y, model(op, x, y));
         wait_done(0, lat, bc, bd, mr);
         checks++;
         if (lat !== exp_lat(op, x, y)) begin
            failures++; $display("FAIL rand%0d_latency got %0d expected %0d", i, lat, exp_lat(op, x, y));
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_normal_ops();
      test_fast_path();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL scoreboard_leftover got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
